// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a five-stage in-order core.
// Resolves load-use stalls, EX-stage redirect flushes and data-memory wait
// freezes, and latches a sticky halt when a memory access never completes.
// Outputs are combinational from the FSM state and current inputs.
// Optional feature: define HAZ_PERF_CNT_EN to build the stall_cycles and
// flush_count performance counters; otherwise both ports are tied to 0.
module hazard_ctrl (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_MemRead,
  input  logic        ex_redirect,
  input  logic        mem_MemRead,
  input  logic        mem_MemWrite,
  input  logic        dmem_ready,
  output logic        dmem_req,
  output logic        PC_write,
  output logic        IFID_write,
  output logic        IDEX_write,
  output logic        EXMEM_write,
  output logic        IFID_flush,
  output logic        IDEX_flush,
  output logic        MEMWB_flush,
  output logic        halt,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] wait_cnt;

  logic mem_acc;
  logic active;
  logic freeze;
  logic load_use;
  logic redirect_apply;
  logic stall_apply;

  // Hazard detection terms; all of them are dead once the FSM reaches ERR.
  always_comb begin
    mem_acc        = mem_MemRead | mem_MemWrite;
    active         = (state == RUN) || (state == MEM_WAIT);
    freeze         = active & mem_acc & ~dmem_ready;
    load_use       = ex_MemRead & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) |
                      (id_use_rs2 & (id_rs2 == ex_rd)));
    redirect_apply = active & ~freeze & ex_redirect;
    stall_apply    = freeze | (active & ~ex_redirect & load_use);
  end

  // Stage enables and bubbles, prioritised ERR > freeze > redirect > load-use.
  always_comb begin
    // NOTE: every output gets a default before the priority chain so that no
    // path leaves a signal unassigned and no latch is inferred.
    dmem_req    = 1'b0;
    PC_write    = 1'b1;
    IFID_write  = 1'b1;
    IDEX_write  = 1'b1;
    EXMEM_write = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    MEMWB_flush = 1'b0;
    halt        = 1'b0;

    if (!RSTn) begin
      // Reset is asynchronous at the outputs too: everything idles low.
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_write  = 1'b0;
      EXMEM_write = 1'b0;
    end else if (state == ERR) begin
      halt        = 1'b1;
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_write  = 1'b0;
      EXMEM_write = 1'b0;
    end else begin
      dmem_req = mem_acc;
      if (freeze) begin
        // Hold the whole front of the pipe; MEM/WB gets a bubble so the
        // unfinished access does not retire.
        PC_write    = 1'b0;
        IFID_write  = 1'b0;
        IDEX_write  = 1'b0;
        EXMEM_write = 1'b0;
        MEMWB_flush = 1'b1;
      end else if (ex_redirect) begin
        // Wrong-path instructions in IF/ID and ID/EX are squashed.
        IFID_flush = 1'b1;
        IDEX_flush = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID for one cycle; a bubble enters ID/EX.
        PC_write   = 1'b0;
        IFID_write = 1'b0;
        IDEX_flush = 1'b1;
      end
    end
  end

  // FSM and memory wait-cycle watchdog.
  always_ff @(posedge CLK or negedge RSTn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!RSTn) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      case (state)
        RUN: begin
          wait_cnt <= 8'd0;
          if (freeze) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (!freeze) begin
            // Acknowledge (or request withdrawn): pipeline advances this cycle.
            state    <= RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == 8'hFF) begin
            state <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ERR:     state <= ERR;
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Performance counters; both wrap naturally at 32 bits.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (stall_apply)    stall_cycles <= stall_cycles + 32'd1;
      if (redirect_apply) flush_count  <= flush_count + 32'd1;
    end
  end
`else
  // Counters not built: ports stay present and read as zero.
  always_comb begin
    stall_cycles = 32'd0;
    flush_count  = 32'd0;
  end

  logic unused_perf;
  assign unused_perf = stall_apply ^ redirect_apply;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have: CLK  in  1  sole clock, rising edge.
REQ-002 SHALL have: RSTn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: id_rs1, id_rs2  in  5 each  ID-stage source register indices.
REQ-004 SHALL have: id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads that source.
REQ-005 SHALL have: ex_rd  in  5;  ex_MemRead  in  1  EX-stage load destination and load flag.
REQ-006 SHALL have: ex_redirect  in  1  taken branch, JAL or JALR resolved in EX.
REQ-007 SHALL have: mem_MemRead, mem_MemWrite  in  1 each  MEM-stage access flags.
REQ-008 SHALL have: dmem_ready  in  1  data-memory completion acknowledge.
REQ-009 SHALL have: dmem_req  out  1  data-memory request.
REQ-010 SHALL have: PC_write, IFID_write, IDEX_write, EXMEM_write  out  1 each  stage register enables.
REQ-011 SHALL have: IFID_flush, IDEX_flush, MEMWB_flush  out  1 each  insert bubble into that stage register.
REQ-012 SHALL have: halt  out  1  sticky memory-timeout error.
REQ-013 SHALL have: stall_cycles, flush_count  out  32 each  performance counters.

Function
REQ-014 SHALL implement a state machine with states RUN, MEM_WAIT, ERR; outputs are combinational from state and inputs.
REQ-015 SHALL define mem_acc = mem_MemRead | mem_MemWrite; dmem_req = mem_acc in RUN/MEM_WAIT, 0 in ERR.
REQ-016 SHALL define freeze = mem_acc & ~dmem_ready in RUN/MEM_WAIT; freeze: PC_write, IFID_write, IDEX_write, EXMEM_write = 0; MEMWB_flush = 1; IFID_flush, IDEX_flush = 0.
REQ-017 SHALL transition RUN->MEM_WAIT on freeze; MEM_WAIT->RUN in the cycle dmem_ready=1 (pipeline advances that same cycle).
REQ-018 SHALL keep 8-bit wait_cnt: clear in RUN and on dmem_ready; increment each MEM_WAIT cycle with dmem_ready=0; at 255 with dmem_ready=0, go ERR next edge.
REQ-019 SHALL in ERR drive halt=1, all *_write=0, all *_flush=0, dmem_req=0, ignore all inputs, exit only via reset.
REQ-020 SHALL, when not freeze and ex_redirect=1: PC_write=1, IFID_write=1, IDEX_write=1, EXMEM_write=1, IFID_flush=1, IDEX_flush=1.
REQ-021 SHALL define load_use = ex_MemRead & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-022 SHALL, when not freeze, not ex_redirect, and load_use: PC_write=0, IFID_write=0, IDEX_flush=1, IDEX_write=1, EXMEM_write=1; one-cycle bubble.
REQ-023 SHALL otherwise drive all *_write=1, all *_flush=0.
REQ-024 SHALL prioritise ERR > freeze > ex_redirect > load_use; ex_redirect masks load_use in the same cycle.
REQ-025 SHALL not count dmem_ready while dmem_req=0; dmem_req stays asserted until acknowledged.

Reset
REQ-026 SHALL while RSTn=0: state=RUN, wait_cnt=0, counters=0, halt=0, dmem_req=0, all *_write=0, all *_flush=0.
REQ-027 SHALL, when RSTn asserts mid-MEM_WAIT or in ERR, abandon the access immediately; first cycle after release is RUN.

Configuration
REQ-028 SHALL, with HAZ_PERF_CNT_EN defined, increment stall_cycles each cycle with freeze or load_use (not ERR), and flush_count each cycle REQ-020 applies; both wrap 0xFFFFFFFF->0.
REQ-029 SHALL, without HAZ_PERF_CNT_EN, keep both ports, drive them constant 0, instantiate no counter flops.

Verification
REQ-030 SHALL cover: ex_MemRead=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> PC_write=0, IFID_write=0, IDEX_flush=1 that cycle only.
REQ-031 SHALL cover: same as REQ-030 plus ex_redirect=1 -> IFID_flush=1, IDEX_flush=1, PC_write=1; ex_rd=0 case -> no stall.
REQ-032 SHALL cover: mem_MemWrite=1, dmem_ready=0 for 3 cycles then 1 -> 3 frozen cycles, MEMWB_flush=1 during them, RUN after; stall_cycles=3.
REQ-033 SHALL cover: mem_MemRead=1, dmem_ready held 0 -> halt=1 after 256 wait cycles, stays 1 until RSTn low.
REQ-034 SHALL cover: RSTn low during MEM_WAIT -> outputs at reset values asynchronously; after release, state RUN, wait_cnt=0.
REQ-035 SHALL cover: freeze and ex_redirect together -> freeze outputs only; flush occurs in the cycle dmem_ready=1.
